pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. Merges three stall and flush sources into one set of per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers:
- load-use hazard (load in EX, dependent instruction in ID)
- taken branch/jump resolved in EX
- multi-cycle data-memory handshake in MEM

It replaces ad-hoc stall wiring and adds a data-memory wait state machine with timeout detection.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for dmem_ack before error; legal range 2..255
CNT_W, 16, width of stall_cycles performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_instruction  in  32  instruction in ID stage
ex_rd_addr  in  5  destination register of the instruction in EX
ex_mem_rd_en  in  1  instruction in EX is a load
ex_branch_taken  in  1  EX resolved taken branch/JAL/JALR
dmem_req  in  1  MEM stage requests data-memory access
dmem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID hold when 0
if_id_flush  out  1  IF/ID load NOP
id_ex_en  out  1  ID/EX hold when 0
id_ex_flush  out  1  ID/EX load bubble
ex_mem_en  out  1  EX/MEM hold when 0
mem_wb_flush  out  1  MEM/WB load bubble
mem_err  out  1  sticky data-memory timeout
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Clock, reset and timing:
  - Single clock domain; reset is synchronous, active-high, on rst, sampled at posedge clk.
  - All control outputs are combinational from the current inputs and registered state, with zero latency.
  - State, wait_cnt, mem_err and stall_cycles are registered.
- While rst=1 (reset values):
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0
  - if_id_flush=1, id_ex_flush=1, mem_wb_flush=1
  - mem_err=0, stall_cycles=0, state=RUN, wait_cnt=0
- Source-register decode from id_instruction[6:0]:
  - R-type 0110011, store 0100011, branch 1100011: rs1 = [19:15] and rs2 = [24:20]
  - I-arith 0010011, load 0000011, JALR 1100111: rs1 only
  - LUI, AUIPC, JAL and all other opcodes: no sources
- load_use = ex_mem_rd_en & ex_rd_addr!=0 & ex_rd_addr matches a used source.
- mem_freeze = (dmem_req & !dmem_ack) | state==ERR.
- Priority (highest first):
  1. mem_freeze: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, no other flushes. Branch and load-use are ignored; they are re-evaluated after release.
  2. ex_branch_taken: pc_en=1, if_id_flush=1, id_ex_flush=1. Overrides a simultaneous load_use, since the dependent instruction is squashed.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble per hazard.
  4. Otherwise all enables=1 and all flushes=0.
- FSM states:
  - RUN:
    - dmem_req & !dmem_ack -> MEM_WAIT, wait_cnt=1.
    - dmem_req & dmem_ack in the same cycle -> no stall, stay in RUN.
  - MEM_WAIT:
    - dmem_ack=1 -> release this same cycle (normal priority applies), -> RUN, wait_cnt=0.
    - Else, if wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_err=1.
    - Else wait_cnt+1.
    - dmem_req dropping without ack is treated as ack (release, -> RUN).
  - ERR: full freeze; exited only by rst. mem_err stays 1.
- stall_cycles:
  - +1 on every non-reset cycle with pc_en=0.
  - Saturates at all-ones, with no wrap.
- Reset in MEM_WAIT or ERR -> RUN next cycle, counters cleared.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: stall_cycles counter is implemented as above.
- Undefined: no counter registers; stall_cycles is tied to 0. All control behaviour is identical.

Test Plan:
- Load-use: EX ex_mem_rd_en=1, ex_rd_addr=6; ID add x28,x6,x30 (0x01E30E33) -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1.
- x0 and no-source exclusion:
  - ex_rd_addr=0 with a dependent R-type -> no stall.
  - ex_rd_addr=6 with LUI in ID -> no stall.
- Branch vs load-use: load_use and ex_branch_taken together -> pc_en=1, if_id_flush=1, id_ex_flush=1.
- Memory wait: dmem_req=1, ack low for 3 cycles then high -> 3 frozen cycles (mem_wb_flush=1), release on the ack cycle, state back to RUN. With STALL_PERF_CNT_EN, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_req held, no ack -> mem_err=1 after 4 wait cycles, permanent freeze. rst pulse -> mem_err=0, normal flow resumes.
- Reset mid-wait: rst during MEM_WAIT at wait_cnt=2 -> reset values that cycle; after rst deasserts with dmem_req=0, all enables=1 and stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline sequencer. It merges the load-use, taken-branch
//               and data-memory wait sources into per-stage enable and flush
//               controls. Optional macro: STALL_PERF_CNT_EN (stall counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_instruction,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_mem_rd_en,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR      = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [1:0] state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;

   logic       use_rs1, use_rs2;
   logic       load_use, mem_freeze;
   logic [4:0] rs1, rs2;

   assign rs1 = id_instruction[19:15];
   assign rs2 = id_instruction[24:20];

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (id_instruction[6:0])
         OP_R, OP_STORE, OP_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_IARITH, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign load_use = ex_mem_rd_en && (ex_rd_addr != 5'd0) &&
                     ((use_rs1 && (rs1 == ex_rd_addr)) || (use_rs2 && (rs2 == ex_rd_addr)));

   assign mem_freeze = (dmem_req && !dmem_ack) || (state_q == ST_ERR);

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (mem_freeze) begin
         // Branch and load-use are held off; they re-evaluate once memory releases.
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         ST_RUN: begin
            if (dmem_req && !dmem_ack) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         ST_MEM_WAIT: begin
            // A dropped request is released exactly like an acknowledge.
            if (!dmem_req || dmem_ack) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = ST_ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_ERR: ;
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err = rst ? 1'b0 : mem_err_q;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = rst ? '0 : stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized checks of pipe_hazard_ctrl against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 5;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      id_instruction;
   logic [4:0]       ex_rd_addr;
   logic             ex_mem_rd_en;
   logic             ex_branch_taken;
   logic             dmem_req;
   logic             dmem_ack;
   logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic             ex_mem_en, mem_wb_flush, mem_err;
   logic [CNT_W-1:0] stall_cycles;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_instruction(id_instruction), .ex_rd_addr(ex_rd_addr),
      .ex_mem_rd_en(ex_mem_rd_en), .ex_branch_taken(ex_branch_taken),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
      .stall_cycles(stall_cycles)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model state: consecutive unacknowledged cycles, sticky error, stall count.
   int m_waited = 0;
   bit m_err    = 1'b0;
   int m_stall  = 0;

   localparam logic [31:0] I_ADD = 32'h01E30E33;
   localparam logic [31:0] I_LUI = 32'h12345337;
   localparam logic [31:0] I_NOP = 32'h00000013;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
      case (ins[6:0])
         7'b0110011, 7'b0100011, 7'b1100011: return (ins[19:15] == r) || (ins[24:20] == r);
         7'b0010011, 7'b0000011, 7'b1100111: return ins[19:15] == r;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step(input bit r, input logic [31:0] ins, input logic [4:0] rd,
                       input bit ld, input bit br, input bit req, input bit ack);
      bit frz, lu;
      bit e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl;
      int e_stall;
      rst = r; id_instruction = ins; ex_rd_addr = rd; ex_mem_rd_en = ld;
      ex_branch_taken = br; dmem_req = req; dmem_ack = ack;
      @(negedge clk);
      frz = m_err || (req && !ack);
      lu  = ld && (rd != 5'd0) && reads_reg(ins, rd);
      {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl} = 7'b1101010;
      if (r)        {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl} = 7'b0010101;
      else if (frz) {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl} = 7'b0000001;
      else if (br)  {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl} = 7'b1111110;
      else if (lu)  {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwfl} = 7'b0001110;
`ifdef STALL_PERF_CNT_EN
      e_stall = r ? 0 : m_stall;
`else
      e_stall = 0;
`endif
      chk("pc_en",        32'(pc_en),        32'(e_pc));
      chk("if_id_en",     32'(if_id_en),     32'(e_ifen));
      chk("if_id_flush",  32'(if_id_flush),  32'(e_iffl));
      chk("id_ex_en",     32'(id_ex_en),     32'(e_idexen));
      chk("id_ex_flush",  32'(id_ex_flush),  32'(e_idexfl));
      chk("ex_mem_en",    32'(ex_mem_en),    32'(e_exmem));
      chk("mem_wb_flush", 32'(mem_wb_flush), 32'(e_mwfl));
      chk("mem_err",      32'(mem_err),      32'(r ? 1'b0 : m_err));
      chk("stall_cycles", 32'(stall_cycles), 32'(e_stall));
      @(posedge clk);
      if (r) begin
         m_waited = 0; m_err = 1'b0; m_stall = 0;
      end else begin
         if (!e_pc && m_stall < CNT_MAX) m_stall++;
         if (!m_err) begin
            if (req && !ack) begin
               m_waited++;
               if (m_waited == MEM_TIMEOUT) m_err = 1'b1;
            end else begin
               m_waited = 0;
            end
         end
      end
      #1;
   endtask

   logic [6:0] ops [8] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
                           7'b0000011, 7'b1100111, 7'b0110111, 7'b1101111};

   initial begin
      rst = 1'b1; id_instruction = I_NOP; ex_rd_addr = 5'd0; ex_mem_rd_en = 1'b0;
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
      step(1, I_NOP, 0, 0, 0, 0, 0);
      step(1, I_NOP, 0, 0, 0, 0, 0);
      // Load-use bubble then free flow
      step(0, I_ADD, 6, 1, 0, 0, 0);
      step(0, I_NOP, 6, 0, 0, 0, 0);
      // x0 destination and sourceless instruction
      step(0, I_ADD, 0, 1, 0, 0, 0);
      step(0, I_LUI, 6, 1, 0, 0, 0);
      // Branch beats load-use
      step(0, I_ADD, 6, 1, 1, 0, 0);
      // Three-cycle memory wait, release on ack, then a same-cycle ack
      repeat (3) step(0, I_NOP, 0, 0, 0, 1, 0);
      step(0, I_NOP, 0, 0, 0, 1, 1);
      step(0, I_NOP, 0, 0, 0, 1, 1);
      step(0, I_NOP, 0, 0, 0, 0, 0);
      // Dropped request releases the wait
      step(0, I_NOP, 0, 0, 0, 1, 0);
      step(0, I_ADD, 6, 1, 1, 0, 0);
      // Timeout into permanent freeze, then recovery by reset
      repeat (6) step(0, I_NOP, 0, 0, 0, 1, 0);
      step(0, I_ADD, 6, 1, 1, 0, 0);
      step(0, I_NOP, 0, 0, 0, 1, 1);
      step(1, I_NOP, 0, 0, 0, 0, 0);
      step(0, I_NOP, 0, 0, 0, 0, 0);
      // Reset mid-wait
      repeat (2) step(0, I_NOP, 0, 0, 0, 1, 0);
      step(1, I_NOP, 0, 0, 0, 1, 0);
      step(0, I_NOP, 0, 0, 0, 0, 0);
      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         logic [31:0] ins;
         ins        = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 7)];
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         step(($urandom_range(0, 59) == 0), ins, 5'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
